// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-access load/store controller with base+/-operand addressing and req/ack handshake.
// Optional alignment check enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_ctrl #(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              op_store,
   input  logic              op_mem,
   input  logic              add_sub,
   input  logic [DATA_W-1:0] dinA,
   input  logic [DATA_W-1:0] dinB,
   input  logic [DATA_W-1:0] offset,
   input  logic [DATA_W-1:0] store_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] load_data
);
   typedef enum logic [1:0] {IDLE, ADDR, REQ, DONE} state_t;
   state_t state_q, state_d;
   logic st_q, om_q, as_q, req_q, ack, mis;
   logic [DATA_W-1:0] a_q, b_q, off_q, sd_q, addr_q, wdata_q, ld_q, opnd, sum;
   assign opnd = om_q ? off_q : b_q;
   assign sum  = as_q ? a_q - opnd : a_q + opnd;
   // mem_req is registered, so the first REQ cycle is an address setup cycle
   assign ack  = (state_q == REQ) && req_q && mem_ack;
`ifdef MEM_ALIGN_CHECK_EN
   logic err_q;
   assign mis = |sum[2:0];
   assign err = err_q;
   always_ff @(posedge clk)
      if (rst)
         err_q <= 1'b0;
      else if (state_q == IDLE && start)
         err_q <= 1'b0;
      else if (state_q == ADDR)
         err_q <= mis;
`else
   assign mis = 1'b0;
   assign err = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = start ? ADDR : IDLE;
         ADDR:    state_d = mis ? DONE : REQ;
         REQ:     state_d = ack ? DONE : REQ;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         {st_q, om_q, as_q, req_q} <= '0;
         {a_q, b_q, off_q, sd_q} <= '0;
         {addr_q, wdata_q, ld_q} <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= (state_q == REQ) && !ack;
         if (state_q == IDLE && start) begin
            {st_q, om_q, as_q} <= {op_store, op_mem, add_sub};
            {a_q, b_q, off_q, sd_q} <= {dinA, dinB, offset, store_data};
         end
         if (state_q == ADDR) begin
            addr_q  <= sum;
            wdata_q <= sd_q;
         end
         if (ack && !st_q)
            ld_q <= mem_rdata;
      end
   end
   assign mem_req   = req_q;
   assign mem_we    = req_q & st_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign load_data = ld_q;
   assign busy      = state_q != IDLE;
   assign done      = state_q == DONE;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of mem_access_ctrl timing, arithmetic, wait states and reset.
module tb_mem_access_ctrl;
   logic clk = 1'b0, rst, start, op_store, op_mem, add_sub, mem_ack;
   logic [63:0] dinA, dinB, offset, store_data, mem_rdata;
   logic mem_req, mem_we, busy, done, err;
   logic [63:0] mem_addr, mem_wdata, load_data;
   int n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   mem_access_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .op_store(op_store), .op_mem(op_mem),
      .add_sub(add_sub), .dinA(dinA), .dinB(dinB), .offset(offset),
      .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .busy(busy), .done(done), .err(err),
      .load_data(load_data)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [63:0] a, b, off, sd, input logic st, om, as);
      dinA = a; dinB = b; offset = off; store_data = sd;
      op_store = st; op_mem = om; add_sub = as;
      start = 1'b1;
      tick;
      start = 1'b0;
      dinA = ~a; dinB = ~b; offset = ~off; store_data = ~sd;
   endtask

   task automatic do_access(input logic [63:0] a, b, off, sd, input logic st, om, as,
                            input int ws, input logic [63:0] rd, exp_addr, exp_ld);
      drive(a, b, off, sd, st, om, as);
      chk("busy_addr", busy, 1);
      chk("req_addr", mem_req, 0);
      mem_ack = 1'b1;
      tick;
      mem_ack = 1'b0;
      chk("addr", mem_addr, exp_addr);
      chk("wdata", mem_wdata, sd);
      chk("req_setup", mem_req, 0);
      chk("err", err, 0);
      tick;
      for (int i = 0; i < ws; i++) begin
         chk("req_wait", mem_req, 1);
         chk("addr_hold", mem_addr, exp_addr);
         chk("done_wait", done, 0);
         start = 1'b1;
         tick;
      end
      start = 1'b0;
      chk("req", mem_req, 1);
      chk("we", mem_we, st);
      chk("addr_req", mem_addr, exp_addr);
      mem_ack = 1'b1;
      mem_rdata = rd;
      tick;
      mem_ack = 1'b0;
      mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
      chk("done", done, 1);
      chk("req_off", mem_req, 0);
      chk("load_data", load_data, exp_ld);
      tick;
      chk("done_once", done, 0);
      chk("busy_idle", busy, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op_store = 1'b0; op_mem = 1'b0; add_sub = 1'b0;
      mem_ack = 1'b0; dinA = '0; dinB = '0; offset = '0; store_data = '0; mem_rdata = '0;
      tick;
      tick;
      rst = 1'b0;
      chk("rst_req", mem_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_ld", load_data, 0);
      do_access(32, 8, 0, 0, 0, 0, 0, 0, 64'hAB, 40, 64'hAB);
      do_access(32, 8, 0, 7, 1, 0, 1, 0, 64'h55, 24, 64'hAB);
      do_access(100, 4, 0, 0, 0, 0, 0, 5, 64'h1234, 104, 64'h1234);
      do_access(0, 8, 0, 0, 0, 0, 1, 0, 64'h77, 64'hFFFF_FFFF_FFFF_FFF8, 64'h77);
      do_access(16, 3, 8, 0, 0, 1, 0, 0, 64'h99, 24, 64'h99);
`ifdef MEM_ALIGN_CHECK_EN
      drive(16, 0, 5, 0, 0, 1, 0);
      tick;
      chk("mis_done", done, 1);
      chk("mis_err", err, 1);
      chk("mis_req", mem_req, 0);
      tick;
      chk("mis_err_hold", err, 1);
      chk("mis_busy", busy, 0);
      chk("mis_req_idle", mem_req, 0);
      do_access(8, 8, 0, 0, 0, 0, 0, 0, 64'h42, 16, 64'h42);
`else
      do_access(16, 0, 5, 0, 0, 1, 0, 0, 64'h42, 21, 64'h42);
`endif
      mem_ack = 1'b1;
      mem_rdata = 64'h1111;
      tick;
      mem_ack = 1'b0;
      chk("ack_idle_ld", load_data, 64'h42);
      chk("ack_idle_done", done, 0);
      drive(32, 8, 0, 9, 1, 0, 0);
      tick;
      tick;
      chk("pre_rst_req", mem_req, 1);
      rst = 1'b1;
      mem_ack = 1'b1;
      tick;
      rst = 1'b0;
      mem_ack = 1'b0;
      chk("rreq_req", mem_req, 0);
      chk("rreq_we", mem_we, 0);
      chk("rreq_busy", busy, 0);
      chk("rreq_done", done, 0);
      chk("rreq_addr", mem_addr, 0);
      chk("rreq_wdata", mem_wdata, 0);
      chk("rreq_ld", load_data, 0);
      chk("rreq_err", err, 0);
      tick;
      chk("rreq_done2", done, 0);
      do_access(8, 8, 0, 0, 0, 0, 0, 0, 64'h5, 16, 64'h5);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: DATA_W, default 64, width of operands, address and data buses.
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request strobe, sampled only in IDLE.
REQ-005 Port: op_store  input  1  0 = load, 1 = store.
REQ-006 Port: op_mem  input  1  second operand select: 0 = dinB, 1 = offset.
REQ-007 Port: add_sub  input  1  0 = base + operand, 1 = base - operand.
REQ-008 Port: dinA, dinB, offset, store_data  input  DATA_W each  base, register operand, immediate offset, store data.
REQ-009 Port: mem_req  output  1  memory request, held until acknowledged.
REQ-010 Port: mem_we  output  1  write enable, valid while mem_req=1.
REQ-011 Port: mem_addr, mem_wdata  output  DATA_W each  registered address and write data.
REQ-012 Port: mem_ack  input  1  memory acknowledge; rdata valid in the same cycle.
REQ-013 Port: mem_rdata  input  DATA_W  memory read data.
REQ-014 Port: busy, done, err  output  1 each  not-IDLE flag, one-cycle completion pulse, alignment error flag.
REQ-015 Port: load_data  output  DATA_W  last captured load result.

Function
REQ-016 The FSM SHALL have states IDLE, ADDR, REQ and DONE.
REQ-017 IDLE with start=1: latch all request inputs and go to ADDR; start is ignored in every other state.
REQ-018 ADDR: register mem_addr = dinA ± (op_mem ? offset : dinB), mod 2^DATA_W with no overflow flag, and register mem_wdata = store_data; go to REQ.
REQ-019 REQ: mem_req=1 and mem_we=op_store are held stable until mem_ack=1, with no timeout.
REQ-020 REQ with mem_ack=1: on a load, capture mem_rdata into load_data (store leaves it unchanged); deassert mem_req on the next edge and go to DONE.
REQ-021 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-022 mem_ack outside REQ SHALL be ignored.
REQ-023 Minimum latency: start sampled at edge N, mem_req high from edge N+2, done high after edge N+3 when mem_ack arrives in the first REQ cycle.
REQ-024 busy=1 in ADDR, REQ and DONE; busy=0 in IDLE.
REQ-025 Back-to-back: start=1 in the cycle after done is accepted as a new request.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE and clear mem_req, mem_we, mem_addr, mem_wdata, load_data, busy, done and err to 0.
REQ-027 rst takes priority over start and mem_ack.
REQ-028 If rst occurs while in REQ, mem_req drops at that edge and the pending access is abandoned without a done pulse.

Configuration
REQ-029 Macro MEM_ALIGN_CHECK_EN: when defined, ADDR SHALL check the computed address.
REQ-030 With the macro, an address where mem_addr[2:0] != 0 goes to DONE with err=1 and issues no mem_req.
REQ-031 With the macro, err stays set until the next accepted start or rst.
REQ-032 Without the macro, no alignment check is made and err is constant 0.

Verification
REQ-033 Load: dinA=32, dinB=8, op_mem=0, add_sub=0, mem_rdata=0xAB, mem_ack in first REQ cycle -> mem_addr=40, mem_we=0, done pulses at N+3, load_data=0xAB.
REQ-034 Store with subtraction: dinA=32, dinB=8, add_sub=1, op_store=1, store_data=7 -> mem_addr=24, mem_we=1, mem_wdata=7, load_data unchanged.
REQ-035 Wait states: mem_ack delayed 5 cycles -> mem_req and mem_addr stay stable for 5 cycles, done at N+8, start pulses during busy are ignored.
REQ-036 Wrap-around: dinA=0, dinB=8, add_sub=1 -> mem_addr=0xFFFF_FFFF_FFFF_FFF8, no error.
REQ-037 Offset misaligned: dinA=16, offset=5, op_mem=1 -> with macro: err=1, done pulses, mem_req never asserted; without macro: mem_addr=21 and a normal access occurs.
REQ-038 Reset in REQ: assert rst while mem_req=1 -> all outputs 0 after that edge, no done pulse, and the next start is served normally.
